dense_inner_acc: RTL and testbench



---
 rtl/dense_inner_acc_pkg.sv | 26 ++
 rtl/dense_add_tree.sv | 65 ++++++
 rtl/dense_inner_acc.sv | 120 ++++++++++++
 tb/tb_dense_inner_acc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dense_inner_acc_pkg.sv
// Shared constants and elaboration helpers for the dense-layer dot-product engine.
// The tree's stage count and per-level widths are derived here.
package dense_inner_acc_pkg;

  localparam int TRAIN_N_LEN = 16;
  localparam int TRAIN_F_LEN = 8;

  typedef struct packed {
    logic first;
    logic last;
  } beat_tag_t;

  // Number of pairwise adder levels needed to reduce n operands; 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Operand count remaining after s adder levels (each level rounds up).
  function automatic int lvl_cnt(input int n, input int s);
    return (n + (1 << s) - 1) >> s;
  endfunction

endpackage

// File: rtl/dense_add_tree.sv
// Pipelined pairwise reduction of N_IN signed operands with a sideband that
// travels alongside the data. Latency is clog2(N_IN) cycles; sums wrap.
module dense_add_tree
  import dense_inner_acc_pkg::*;
#(
  parameter int N_IN      = 10,
  parameter int ACC_WIDTH = 32,
  parameter int TAG_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [N_IN*ACC_WIDTH-1:0]   data_i,
  output logic                        valid_o,
  output logic [TAG_W-1:0]            tag_o,
  output logic signed [ACC_WIDTH-1:0] sum_o
);

  localparam int ADD_STAGES = clog2(N_IN);

  for (genvar s = 0; s <= ADD_STAGES; s++) begin : g_lvl
    localparam int CNT = lvl_cnt(N_IN, s);
    logic signed [ACC_WIDTH-1:0] sum_q [CNT];
    logic                        vld_q;
    logic [TAG_W-1:0]            tag_q;

    if (s == 0) begin : g_in
      for (genvar j = 0; j < CNT; j++) begin : g_lane
        assign sum_q[j] = data_i[j*ACC_WIDTH +: ACC_WIDTH];
      end
      assign vld_q = valid_i;
      assign tag_q = tag_i;
    end else begin : g_add
      localparam int PREV = lvl_cnt(N_IN, s - 1);
      logic signed [ACC_WIDTH-1:0] sum_d [CNT];

      // An odd operand at the end of a level is forwarded unchanged.
      for (genvar j = 0; j < CNT; j++) begin : g_node
        if (2*j + 1 < PREV) begin : g_pair
          assign sum_d[j] = g_lvl[s-1].sum_q[2*j] + g_lvl[s-1].sum_q[2*j+1];
        end else begin : g_pass
          assign sum_d[j] = g_lvl[s-1].sum_q[2*j];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          tag_q <= '0;
          sum_q <= '{default: '0};
        end else begin
          vld_q <= g_lvl[s-1].vld_q;
          tag_q <= g_lvl[s-1].tag_q;
          sum_q <= sum_d;
        end
      end
    end
  end

  assign valid_o = g_lvl[ADD_STAGES].vld_q;
  assign tag_o   = g_lvl[ADD_STAGES].tag_q;
  assign sum_o   = g_lvl[ADD_STAGES].sum_q[0];

endmodule

// File: rtl/dense_inner_acc.sv
// Fixed-point dot-product engine: per-lane multiply, pipelined adder tree,
// multi-beat accumulator and saturating output with overflow flag.
module dense_inner_acc
  import dense_inner_acc_pkg::*;
#(
  parameter int N_IN        = 10,
  parameter int DATA_WIDTH1 = TRAIN_N_LEN,
  parameter int DATA_WIDTH2 = TRAIN_N_LEN,
  parameter int F_LEN       = TRAIN_F_LEN,
  parameter int ACC_WIDTH   = DATA_WIDTH1 + DATA_WIDTH2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic                          first,
  input  logic                          last,
  input  logic [N_IN*DATA_WIDTH1-1:0]   d1,
  input  logic [N_IN*DATA_WIDTH2-1:0]   d2,
  output logic                          valid_out,
  output logic [DATA_WIDTH1-1:0]        q,
  output logic                          ovf
);

  localparam int PW    = DATA_WIDTH1 + DATA_WIDTH2;
  localparam int TAG_W = $bits(beat_tag_t);

  // Full product, floor-shifted, then sign-extended or truncated to ACC_WIDTH.
  function automatic logic signed [ACC_WIDTH-1:0] lane_prod(
    input logic signed [DATA_WIDTH1-1:0] a,
    input logic signed [DATA_WIDTH2-1:0] b
  );
    logic signed [PW-1:0]           p;
    logic signed [PW+ACC_WIDTH-1:0] w;
    p = a * b;
    w = p;
    w = w >>> F_LEN;
    return w[ACC_WIDTH-1:0];
  endfunction

  // Returns {ovf, q}: the value fits when all bits above the output sign bit agree.
  function automatic logic [DATA_WIDTH1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-DATA_WIDTH1:0] hi;
    hi = v[ACC_WIDTH-1:DATA_WIDTH1-1];
    if ((&hi) || !(|hi)) return {1'b0, v[DATA_WIDTH1-1:0]};
    else if (v[ACC_WIDTH-1]) return {2'b11, {(DATA_WIDTH1-1){1'b0}}};
    else return {2'b10, {(DATA_WIDTH1-1){1'b1}}};
  endfunction

  logic [N_IN*ACC_WIDTH-1:0] prod_d, prod_q;
  logic                      vld_m_q;
  beat_tag_t                 tag_m_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_mul
    assign prod_d[i*ACC_WIDTH +: ACC_WIDTH] =
      lane_prod(d1[i*DATA_WIDTH1 +: DATA_WIDTH1], d2[i*DATA_WIDTH2 +: DATA_WIDTH2]);
  end

  // Stage M: lane products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_m_q <= 1'b0;
      tag_m_q <= '0;
      prod_q  <= '0;
    end else begin
      vld_m_q <= valid_in;
      tag_m_q <= '{first: first, last: last};
      prod_q  <= prod_d;
    end
  end

  logic                        tree_vld;
  logic [TAG_W-1:0]            tree_tag_raw;
  beat_tag_t                   tree_tag;
  logic signed [ACC_WIDTH-1:0] beat_sum;

  dense_add_tree #(
    .N_IN      (N_IN),
    .ACC_WIDTH (ACC_WIDTH),
    .TAG_W     (TAG_W)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .valid_i (vld_m_q),
    .tag_i   (tag_m_q),
    .data_i  (prod_q),
    .valid_o (tree_vld),
    .tag_o   (tree_tag_raw),
    .sum_o   (beat_sum)
  );

  assign tree_tag = beat_tag_t'(tree_tag_raw);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH1:0]        sat_d;

  always_comb begin
    acc_d = tree_tag.first ? beat_sum : acc_q + beat_sum;
    sat_d = sat_out(acc_d);
  end

  // Stage A: accumulate; acc survives last and bubbles, only first restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      valid_out <= 1'b0;
      q         <= '0;
      ovf       <= 1'b0;
    end else begin
      valid_out <= tree_vld && tree_tag.last;
      if (tree_vld) begin
        acc_q <= acc_d;
        if (tree_tag.last) begin
          q   <= sat_d[DATA_WIDTH1-1:0];
          ovf <= sat_d[DATA_WIDTH1];
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_inner_acc.sv
// Randomized and directed bench for dense_inner_acc against an arithmetic dot-product model.
`timescale 1ns/1ps
module tb_dense_inner_acc;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int LAT = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_in = 1'b0;
  logic             first = 1'b0;
  logic             last = 1'b0;
  logic [N*W-1:0]   d1 = '0;
  logic [N*W-1:0]   d2 = '0;
  logic             valid_out;
  logic [W-1:0]     q;
  logic             ovf;

  dense_inner_acc dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .first     (first),
    .last      (last),
    .d1        (d1),
    .d2        (d2),
    .valid_out (valid_out),
    .q         (q),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int           due;
    logic [W-1:0] q;
    logic         ovf;
  } exp_t;

  exp_t expq[$];
  int   acc_m = 0;

  function automatic int model_sum(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    longint s, p, f;
    s = 0;
    for (int i = 0; i < N; i++) begin
      p = longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]));
      f = p / 256;
      if (p < 0 && (p % 256) != 0) f = f - 1;
      s += f;
    end
    return int'(s);
  endfunction

  task automatic beat(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                      input logic f, input logic l);
    exp_t e;
    int   s;
    @(posedge clk); #1;
    valid_in = 1'b1; first = f; last = l; d1 = a; d2 = b;
    s = model_sum(a, b);
    acc_m = f ? s : acc_m + s;
    if (l) begin
      e.due = cyc + LAT;
      if (acc_m > 32767) begin e.q = 16'h7FFF; e.ovf = 1'b1; end
      else if (acc_m < -32768) begin e.q = 16'h8000; e.ovf = 1'b1; end
      else begin e.q = acc_m[W-1:0]; e.ovf = 1'b0; end
      expq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      first = $urandom_range(0, 1);
      last = $urandom_range(0, 1);
      d1 = {5{$urandom()}};
      d2 = {5{$urandom()}};
    end
  endtask

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [N*W-1:0] lane0(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] gen(input int mode);
    logic [N*W-1:0] r;
    int             v;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) v = $urandom();
      else if (mode == 1) v = $urandom_range(0, 1023) - 512;
      else v = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 8191) - 4096;
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        check("valid_out", valid_out, 1);
        check("q", q, expq[0].q);
        check("ovf", ovf, expq[0].ovf);
        void'(expq.pop_front());
      end else begin
        check("no_valid_out", valid_out, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    logic cont;
    int mode;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_q", q, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    idle(2);

    beat(fill(16'h0100), fill(16'h0080), 1'b1, 1'b1);
    idle(8);

    beat(fill(16'h0100), fill(16'h0080), 1'b1, 1'b0);
    beat(fill(16'h0100), fill(16'h0080), 1'b0, 1'b0);
    beat(fill(16'h0100), fill(16'h0080), 1'b0, 1'b1);
    idle(8);
    beat(fill(16'h0100), fill(16'h0080), 1'b1, 1'b0);
    idle(2);
    beat(fill(16'h0100), fill(16'h0080), 1'b0, 1'b0);
    idle(2);
    beat(fill(16'h0100), fill(16'h0080), 1'b0, 1'b1);
    idle(8);

    beat(fill(16'hFF00), fill(16'h0100), 1'b1, 1'b1);
    beat(fill(16'h7FFF), fill(16'h7FFF), 1'b1, 1'b1);
    beat(fill(16'h8000), fill(16'h7FFF), 1'b1, 1'b1);
    beat(lane0(16'h0001), lane0(16'hFFFF), 1'b1, 1'b1);
    idle(8);

    beat(lane0(16'h0100), lane0(16'h0100), 1'b1, 1'b1);
    beat(lane0(16'h0200), lane0(16'h0100), 1'b1, 1'b1);
    beat(lane0(16'h0300), lane0(16'h0100), 1'b1, 1'b1);
    idle(10);

    // Reset three cycles after a single-beat vector; its result must never appear.
    beat(fill(16'h0100), fill(16'h0100), 1'b1, 1'b1);
    idle(2);
    @(posedge clk); #1;
    rst = 1'b1;
    valid_in = 1'b0;
    expq.delete();
    acc_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_q", q, 0);
    check("mid_rst_ovf", ovf, 0);
    idle(8);
    beat(lane0(16'h0200), lane0(16'h0100), 1'b0, 1'b1);
    idle(8);

    for (int v = 0; v < 40; v++) begin
      len  = $urandom_range(1, 4);
      cont = ($urandom_range(0, 7) == 0);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < len; k++) begin
        beat(gen(mode), gen(mode), (k == 0) && !cont, k == len - 1);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end

    idle(12);
    check("drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
